bus_target: RTL and testbench

//  Responder side of the single-master CPU bus: owns the on-chip RAM and the MMIO peripherals.
//  It decodes bus_addr, performs byte-masked writes and returns read data with a fixed
//  1-cycle latency, which is the timing the CPU's fetch/load path requires.

---
 rtl/bus_pkg.sv | 31 +++
 rtl/bus_target_if.sv | 17 +
 rtl/uart_tx.sv | 139 +++++++++++++
 rtl/bus_target.sv | 116 +++++++++++
 tb/tb_bus_target.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// ----------------------------------------------------------------------------
// bus_pkg: shared decode constants, status bit positions and UART state type.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam int MMIO_BIT = 29;

  localparam logic [3:0] OFF_UART_DATA = 4'd0;
  localparam logic [3:0] OFF_UART_STAT = 4'd1;
  localparam logic [3:0] OFF_CYC_LO    = 4'd2;
  localparam logic [3:0] OFF_CYC_HI    = 4'd3;
  localparam logic [3:0] OFF_LEDS      = 4'd4;

  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_BUSY  = 3;
  localparam int STAT_OVF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/bus_target_if.sv
// ----------------------------------------------------------------------------
// bus_target_if: single-master CPU bus, master drives address/write side.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bus_target_if;
  logic [29:0] bus_addr;
  logic [31:0] bus_data_r;
  logic [31:0] bus_data_w;
  logic [3:0]  bus_mask_w;

  modport master (output bus_addr, output bus_data_w, output bus_mask_w, input bus_data_r);
  modport slave  (input bus_addr, input bus_data_w, input bus_mask_w, output bus_data_r);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx: byte FIFO feeding an 8N1 serial transmitter, LSB first, idle high.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
  parameter int unsigned DIV   = 434,
  parameter int unsigned DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  output logic       full,
  output logic       empty,
  input  logic       ovf_clr,
  output logic       ovf,
  output logic       busy,
  output logic       tx
);
  import bus_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);

  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  uart_state_t   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          push_ok, pop;

  // Full is judged before the edge, so a same-cycle pop never rescues a push.
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop     = (state_q == IDLE) & ~empty;
  assign ovf     = ovf_q;
  assign busy    = (state_q != IDLE) | ~empty;
  assign tx      = tx_q;

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW + 1)'(push_ok) - (PW + 1)'(pop);
    ovf_d    = ovf_clr ? 1'b0 : ovf_q;
    if (push && full) ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_target.sv
// ----------------------------------------------------------------------------
// bus_target: bus responder with RAM, UART TX, 64-bit cycle counter and LEDs.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_target #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter string       INIT_FILE  = "",
  parameter int unsigned UART_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  bus_target_if.slave bus,
  output logic        uart_tx,
  output logic [7:0]  leds
);
  import bus_pkg::*;

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   data_r_q, data_r_d;
  logic [63:0]   cyc_q, cyc_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    leds_q, leds_d;
  logic          mmio_sel;
  logic [3:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          uart_push, uart_ovf_clr;
  logic          uart_full, uart_empty, uart_ovf, uart_busy;
  logic          addr_unused;

  assign mmio_sel    = bus.bus_addr[MMIO_BIT];
  assign mmio_off    = bus.bus_addr[3:0];
  assign ram_idx     = bus.bus_addr[AW-1:0];
  assign addr_unused = ^bus.bus_addr[28:0];

  always_ff @(posedge clock) begin
    if (!mmio_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.bus_mask_w[b]) ram[ram_idx][8*b +: 8] <= bus.bus_data_w[8*b +: 8];
      end
    end
  end

  // Everything read here is the pre-edge value, giving read-first behaviour.
  always_comb begin
    data_r_d     = ram[ram_idx];
    snap_d       = snap_q;
    leds_d       = leds_q;
    cyc_d        = cyc_q + 64'd1;
    uart_push    = 1'b0;
    uart_ovf_clr = 1'b0;
    if (mmio_sel) begin
      data_r_d = '0;
      case (mmio_off)
        OFF_UART_DATA: uart_push = bus.bus_mask_w[0];
        OFF_UART_STAT: begin
          data_r_d[STAT_EMPTY] = uart_empty;
          data_r_d[STAT_FULL]  = uart_full;
          data_r_d[STAT_BUSY]  = uart_busy;
          data_r_d[STAT_OVF]   = uart_ovf;
          uart_ovf_clr         = |bus.bus_mask_w;
        end
        OFF_CYC_LO: begin
          data_r_d = cyc_q[31:0];
          snap_d   = cyc_q[63:32];
        end
        OFF_CYC_HI: data_r_d = snap_q;
        OFF_LEDS: begin
          data_r_d = {24'd0, leds_q};
          if (bus.bus_mask_w[0]) leds_d = bus.bus_data_w[7:0];
        end
        default: data_r_d = '0;
      endcase
    end
  end

  // Read data keeps flowing through reset so RAM[0] is ready on release.
  always_ff @(posedge clock) begin
    data_r_q <= data_r_d;
    if (reset) begin
      cyc_q  <= '0;
      snap_q <= '0;
      leds_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      snap_q <= snap_d;
      leds_q <= leds_d;
    end
  end

  assign bus.bus_data_r = data_r_q;
  assign leds           = leds_q;

  uart_tx #(
    .DIV   (UART_DIV),
    .DEPTH (FIFO_DEPTH)
  ) u_uart (
    .clock     (clock),
    .reset     (reset),
    .push      (uart_push),
    .push_data (bus.bus_data_w[7:0]),
    .full      (uart_full),
    .empty     (uart_empty),
    .ovf_clr   (uart_ovf_clr),
    .ovf       (uart_ovf),
    .busy      (uart_busy),
    .tx        (uart_tx)
  );

endmodule

`default_nettype wire

// File: tb/tb_bus_target.sv
// ----------------------------------------------------------------------------
// tb_bus_target: directed checks of RAM, MMIO, counter and UART behaviour.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_target;

  localparam logic [29:0] MMIO = 30'h2000_0000;

  logic       clock = 1'b0;
  logic       reset;
  logic       uart_tx;
  logic [7:0] leds;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rx_q[$];
  logic       mon_en = 1'b0;

  bus_target_if bus ();

  bus_target #(
    .RAM_WORDS  (256),
    .INIT_FILE  (""),
    .UART_DIV   (4),
    .FIFO_DEPTH (16)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .uart_tx (uart_tx),
    .leds    (leds)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One bus cycle; returns 1 time unit after the edge so bus_data_r holds this access's read.
  task automatic cyc_bus(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.bus_addr   = a;
    bus.bus_data_w = d;
    bus.bus_mask_w = m;
    @(posedge clock);
    #1;
  endtask

  // Serial receiver sampling mid-bit for UART_DIV=4.
  initial begin
    logic [7:0] b;
    wait (mon_en);
    forever begin
      @(negedge uart_tx);
      repeat (2) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clock);
        b[i] = uart_tx;
      end
      repeat (4) @(negedge clock);
      rx_q.push_back(b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] frame_byte;
    logic       exp_bit;
    int         seg;

    reset          = 1'b1;
    bus.bus_addr   = '0;
    bus.bus_data_w = '0;
    bus.bus_mask_w = '0;
    cyc_bus(30'd0, 32'd0, 4'd0);
    cyc_bus(30'd0, 32'd0, 4'd0);
    check_eq("rst_tx", uart_tx, 1);
    check_eq("rst_leds", leds, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    cyc_bus(30'd0, 32'hDEADBEEF, 4'hF);
    cyc_bus(MMIO | 30'd4, 32'h0000_005A, 4'h1);
    cyc_bus(MMIO | 30'h34, 32'd0, 4'h0);
    check_eq("leds_rd_alias", bus.bus_data_r, 32'h5A);
    check_eq("leds_port", leds, 8'h5A);

    // Reset with addr=0: reads continue, peripherals held.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc_bus(30'd0, 32'd0, 4'd0);
      check_eq("rst_hold_tx", uart_tx, 1);
      check_eq("rst_hold_leds", leds, 0);
      check_eq("rst_hold_rd", bus.bus_data_r, 32'hDEADBEEF);
    end
    reset = 1'b0;
    cyc_bus(30'd0, 32'd0, 4'd0);
    check_eq("post_rst_rd", bus.bus_data_r, 32'hDEADBEEF);
    cyc_bus(MMIO | 30'd2, 32'd0, 4'd0);
    check_eq("cyc_lo_first", bus.bus_data_r, 32'd1);
    cyc_bus(MMIO | 30'd3, 32'd0, 4'd0);
    check_eq("cyc_hi_first", bus.bus_data_r, 32'd0);
    cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("stat_reset", bus.bus_data_r, 32'h02);

    // Byte-lane write and read-first.
    cyc_bus(30'h10, 32'h11223344, 4'hF);
    cyc_bus(30'h10, 32'h00AB0000, 4'b0100);
    check_eq("byte_wr_readfirst", bus.bus_data_r, 32'h11223344);
    cyc_bus(30'h10, 32'd0, 4'd0);
    check_eq("byte_wr", bus.bus_data_r, 32'h11AB3344);
    cyc_bus(30'h110, 32'd0, 4'd0);
    check_eq("ram_alias", bus.bus_data_r, 32'h11AB3344);

    // Back-to-back write then read.
    cyc_bus(30'd5, 32'h12345678, 4'hF);
    cyc_bus(30'd5, 32'hCAFEF00D, 4'hF);
    check_eq("b2b_readfirst", bus.bus_data_r, 32'h12345678);
    cyc_bus(30'd5, 32'd0, 4'd0);
    check_eq("b2b_read", bus.bus_data_r, 32'hCAFEF00D);

    cyc_bus(MMIO | 30'd7, 32'hFFFFFFFF, 4'hF);
    cyc_bus(MMIO | 30'd7, 32'd0, 4'd0);
    check_eq("unmapped", bus.bus_data_r, 32'd0);
    cyc_bus(MMIO | 30'd0, 32'd0, 4'd0);
    check_eq("uart_data_rd", bus.bus_data_r, 32'd0);

    // Counter coherence across the 32-bit carry.
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    cyc_bus(MMIO | 30'd2, 32'd0, 4'd0);
    check_eq("cyc_lo_wrap", bus.bus_data_r, 32'hFFFFFFFF);
    release dut.cyc_q;
    cyc_bus(MMIO | 30'd3, 32'd0, 4'd0);
    check_eq("cyc_hi_snap", bus.bus_data_r, 32'h0);

    // Single frame waveform.
    frame_byte = 8'hA5;
    cyc_bus(MMIO | 30'd0, 32'h0000_00A5, 4'h1);
    bus.bus_addr   = MMIO | 30'd1;
    bus.bus_mask_w = 4'h0;
    @(negedge clock);
    check_eq("frame_idle", uart_tx, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      seg = i / 4;
      if (seg == 0)      exp_bit = 1'b0;
      else if (seg == 9) exp_bit = 1'b1;
      else               exp_bit = frame_byte[seg-1];
      check_eq("frame_bit", uart_tx, exp_bit);
      if (i == 20) check_eq("stat_busy", bus.bus_data_r, 32'h0A);
    end
    repeat (3) cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("stat_done", bus.bus_data_r, 32'h02);

    // Overflow: first frame in flight, then 17 pushes into a 16-deep FIFO.
    rx_q.delete();
    cyc_bus(MMIO | 30'd0, 32'h10, 4'h1);
    for (int k = 0; k < 8 && uart_tx; k++) cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("ovf_started", uart_tx, 0);
    for (int i = 0; i < 17; i++) cyc_bus(MMIO | 30'd0, 32'h20 + i, 4'h1);
    cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("stat_ovf", bus.bus_data_r, 32'h1C);
    cyc_bus(MMIO | 30'd1, 32'd0, 4'hF);
    check_eq("stat_clr_readfirst", bus.bus_data_r, 32'h1C);
    cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("stat_ovf_cleared", bus.bus_data_r, 32'h0C);
    for (int k = 0; k < 1200 && rx_q.size() < 17; k++) @(posedge clock);
    check_eq("rx_count", rx_q.size(), 17);
    for (int i = 0; i < 17; i++) begin
      check_eq("rx_byte", (i < rx_q.size()) ? rx_q[i] : 8'hXX, (i == 0) ? 8'h10 : 8'h1F + i);
    end
    repeat (10) cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("stat_drained", bus.bus_data_r, 32'h02);

    // Reset mid-frame aborts the frame and flushes the FIFO.
    cyc_bus(MMIO | 30'd4, 32'h0000_00C3, 4'h1);
    cyc_bus(MMIO | 30'd0, 32'h55, 4'h1);
    cyc_bus(MMIO | 30'd0, 32'h66, 4'h1);
    check_eq("abort_started", uart_tx, 0);
    cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    reset = 1'b1;
    cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("abort_tx", uart_tx, 1);
    check_eq("abort_leds", leds, 0);
    reset = 1'b0;
    cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
    check_eq("abort_flush", bus.bus_data_r, 32'h02);
    for (int i = 0; i < 6; i++) begin
      cyc_bus(MMIO | 30'd1, 32'd0, 4'd0);
      check_eq("abort_quiet", uart_tx, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
